cross_domain_clock: RTL and testbench

- Bidirectional clock-domain-crossing bridge between the 125 MHz domain (clk_125) and the 100 MHz domain (clk_100).
- Channel 1 carries a single-cycle trigger plus an 8-bit word from clk_125 into clk_100.
- Channel 2 carries a single-cycle trigger plus a 27-bit word from clk_100 into clk_125.
- Each channel is a toggle-request/toggle-acknowledge handshake with multi-flop synchronizers, so the data bus stays stable in the source domain until the destination has captured it.

---
 rtl/cross_domain_clock.sv | 154 +++++++++++++++
 tb/tb_cross_domain_clock.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cross_domain_clock.sv
// Bidirectional toggle-handshake clock-domain-crossing bridge.
// Channel 1 moves a trigger and a DATA1_W word from clk_125 into clk_100.
// Channel 2 moves a trigger and a DATA2_W word from clk_100 into clk_125.
// Each source parks its word in a holding register and flips a request toggle.
// The destination synchronizes the toggle, copies the held word and pulses action.
// It then returns the seen toggle as an acknowledge. The held word cannot change
// until the acknowledge comes back, so it is stable whenever the destination reads it.
module cross_domain_clock #(
  parameter int DATA1_W     = 8,
  parameter int DATA2_W     = 27,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_125,
  input  logic               clk_100,
  input  logic               reset,
  input  logic               trigger_1,
  input  logic               trigger_2,
  input  logic [DATA1_W-1:0] data_in_1,
  input  logic [DATA2_W-1:0] data_in_2,
  output logic               action_1,
  output logic               action_2,
  output logic [DATA1_W-1:0] data_out_1,
  output logic [DATA2_W-1:0] data_out_2
);

  // Reset distribution into the clk_100 domain
  logic                   rstCopy_q;
  logic [SYNC_STAGES-1:0] rst100Sync_q;
  logic                   rst100;

  // Channel 1 source (clk_125)
  logic                   req1_q, req1_d;
  logic [DATA1_W-1:0]     hold1_q, hold1_d;
  logic [SYNC_STAGES-1:0] ack1Sync_q;
  logic                   idle1, accept1;

  // Channel 1 destination (clk_100)
  logic [SYNC_STAGES-1:0] req1Sync_q;
  logic                   req1Seen_q;
  logic                   action1_q;
  logic [DATA1_W-1:0]     out1_q;
  logic                   change1;

  // Channel 2 source (clk_100)
  logic                   req2_q, req2_d;
  logic [DATA2_W-1:0]     hold2_q, hold2_d;
  logic [SYNC_STAGES-1:0] ack2Sync_q;
  logic                   idle2, accept2;

  // Channel 2 destination (clk_125)
  logic [SYNC_STAGES-1:0] req2Sync_q;
  logic                   req2Seen_q;
  logic                   action2_q;
  logic [DATA2_W-1:0]     out2_q;
  logic                   change2;

  // Registered copy of reset, so only a flop output crosses into clk_100
  always_ff @(posedge clk_125) begin
    rstCopy_q <= reset;
  end

  // Synchronize the reset copy into clk_100; the last stage resets that domain
  always_ff @(posedge clk_100) begin
    rst100Sync_q <= {rst100Sync_q[SYNC_STAGES-2:0], rstCopy_q};
  end

  assign rst100 = rst100Sync_q[SYNC_STAGES-1];

  // Channel 1 source: accept a trigger only while the last request has been acknowledged
  always_comb begin
    idle1   = (req1_q == ack1Sync_q[SYNC_STAGES-1]);
    accept1 = trigger_1 && idle1;
    req1_d  = req1_q ^ accept1;
    hold1_d = accept1 ? data_in_1 : hold1_q;
  end

  // Channel 1 source state and acknowledge synchronizer
  always_ff @(posedge clk_125) begin
    if (reset) begin
      req1_q     <= 1'b0;
      hold1_q    <= '0;
      ack1Sync_q <= '0;
    end else begin
      req1_q     <= req1_d;
      hold1_q    <= hold1_d;
      ack1Sync_q <= {ack1Sync_q[SYNC_STAGES-2:0], req1Seen_q};
    end
  end

  assign change1 = (req1Sync_q[SYNC_STAGES-1] != req1Seen_q);

  // Channel 1 destination: detect a toggle change, capture the held word, pulse action
  always_ff @(posedge clk_100) begin
    if (rst100) begin
      req1Sync_q <= '0;
      req1Seen_q <= 1'b0;
      action1_q  <= 1'b0;
      out1_q     <= '0;
    end else begin
      req1Sync_q <= {req1Sync_q[SYNC_STAGES-2:0], req1_q};
      req1Seen_q <= req1Sync_q[SYNC_STAGES-1];
      action1_q  <= change1;
      if (change1) begin
        out1_q <= hold1_q;
      end
    end
  end

  // Channel 2 source: accept a trigger only while the last request has been acknowledged
  always_comb begin
    idle2   = (req2_q == ack2Sync_q[SYNC_STAGES-1]);
    accept2 = trigger_2 && idle2;
    req2_d  = req2_q ^ accept2;
    hold2_d = accept2 ? data_in_2 : hold2_q;
  end

  // Channel 2 source state and acknowledge synchronizer
  always_ff @(posedge clk_100) begin
    if (rst100) begin
      req2_q     <= 1'b0;
      hold2_q    <= '0;
      ack2Sync_q <= '0;
    end else begin
      req2_q     <= req2_d;
      hold2_q    <= hold2_d;
      ack2Sync_q <= {ack2Sync_q[SYNC_STAGES-2:0], req2Seen_q};
    end
  end

  assign change2 = (req2Sync_q[SYNC_STAGES-1] != req2Seen_q);

  // Channel 2 destination: detect a toggle change, capture the held word, pulse action
  always_ff @(posedge clk_125) begin
    if (reset) begin
      req2Sync_q <= '0;
      req2Seen_q <= 1'b0;
      action2_q  <= 1'b0;
      out2_q     <= '0;
    end else begin
      req2Sync_q <= {req2Sync_q[SYNC_STAGES-2:0], req2_q};
      req2Seen_q <= req2Sync_q[SYNC_STAGES-1];
      action2_q  <= change2;
      if (change2) begin
        out2_q <= hold2_q;
      end
    end
  end

  assign action_1   = action1_q;
  assign action_2   = action2_q;
  assign data_out_1 = out1_q;
  assign data_out_2 = out2_q;

endmodule

// File: tb/tb_cross_domain_clock.sv
// Scoreboard bench for the cross_domain_clock bridge.
// Monitors record every action pulse with its word and time.
// Each test task queues the words it expects and compares them against what was delivered.
module tb_cross_domain_clock;

  logic        clk_125 = 1'b0;
  logic        clk_100 = 1'b0;
  logic        reset = 1'b1;
  logic        trigger_1 = 1'b0;
  logic        trigger_2 = 1'b0;
  logic [7:0]  data_in_1 = '0;
  logic [26:0] data_in_2 = '0;
  logic        action_1;
  logic        action_2;
  logic [7:0]  data_out_1;
  logic [26:0] data_out_2;

  int passCount = 0;
  int checkCount = 0;

  logic [7:0]  exp1[$];
  logic [7:0]  obs1[$];
  time         obs1T[$];
  logic [26:0] exp2[$];
  logic [26:0] obs2[$];
  time         obs2T[$];

  cross_domain_clock #(.DATA1_W(8), .DATA2_W(27), .SYNC_STAGES(2)) dut (
    .clk_125   (clk_125),
    .clk_100   (clk_100),
    .reset     (reset),
    .trigger_1 (trigger_1),
    .trigger_2 (trigger_2),
    .data_in_1 (data_in_1),
    .data_in_2 (data_in_2),
    .action_1  (action_1),
    .action_2  (action_2),
    .data_out_1(data_out_1),
    .data_out_2(data_out_2)
  );

  // Rising edges of the two clocks never coincide (125: 4+8m, 100: 5+10k)
  always #4 clk_125 = ~clk_125;
  always #5 clk_100 = ~clk_100;

  // Record channel 1 deliveries away from the clk_100 rising edge
  always @(negedge clk_100) begin
    if (action_1 === 1'b1) begin
      obs1.push_back(data_out_1);
      obs1T.push_back($time);
    end
  end

  // Record channel 2 deliveries away from the clk_125 rising edge
  always @(negedge clk_125) begin
    if (action_2 === 1'b1) begin
      obs2.push_back(data_out_2);
      obs2T.push_back($time);
    end
  end

  task automatic clear_queues;
    exp1.delete(); obs1.delete(); obs1T.delete();
    exp2.delete(); obs2.delete(); obs2T.delete();
  endtask

  task automatic do_reset;
    @(negedge clk_125);
    reset = 1'b1;
    repeat (12) @(negedge clk_125);
    reset = 1'b0;
    repeat (6) @(negedge clk_100);
    clear_queues();
  endtask

  task automatic send1(input logic [7:0] d, output time tAcc);
    @(negedge clk_125);
    trigger_1 = 1'b1;
    data_in_1 = d;
    @(posedge clk_125);
    tAcc = $time;
    @(negedge clk_125);
    trigger_1 = 1'b0;
    data_in_1 = '0;
  endtask

  task automatic send2(input logic [26:0] d, output time tAcc);
    @(negedge clk_100);
    trigger_2 = 1'b1;
    data_in_2 = d;
    @(posedge clk_100);
    tAcc = $time;
    @(negedge clk_100);
    trigger_2 = 1'b0;
    data_in_2 = '0;
  endtask

  task automatic test_reset;
    do_reset();
    checkCount++;
    if (action_1 !== 1'b0) $display("[TB] FAIL reset_action_1: got %b expected 0", action_1);
    else passCount++;
    checkCount++;
    if (action_2 !== 1'b0) $display("[TB] FAIL reset_action_2: got %b expected 0", action_2);
    else passCount++;
    checkCount++;
    if (data_out_1 !== 8'h00) $display("[TB] FAIL reset_data_out_1: got %h expected 00", data_out_1);
    else passCount++;
    checkCount++;
    if (data_out_2 !== 27'h0) $display("[TB] FAIL reset_data_out_2: got %h expected 0", data_out_2);
    else passCount++;
  endtask

  task automatic test_ch2_basic;
    time tAcc, ot, lat;
    logic [26:0] e, o;
    do_reset();
    exp2.push_back(27'h0003000);
    send2(27'h0003000, tAcc);
    repeat (20) @(negedge clk_125);
    checkCount++;
    if (obs2.size() != 1) $display("[TB] FAIL ch2_pulse_count: got %0d expected 1", obs2.size());
    else passCount++;
    checkCount++;
    if (obs2.size() == 0) $display("[TB] FAIL ch2_data: got no pulse expected %h", exp2[0]);
    else begin
      e = exp2.pop_front(); o = obs2.pop_front(); ot = obs2T.pop_front();
      if (o !== e) $display("[TB] FAIL ch2_data: got %h expected %h", o, e);
      else passCount++;
      lat = ot - 4 - tAcc;
      checkCount++;
      if (!(lat > 16 && lat <= 32)) $display("[TB] FAIL ch2_latency: got %0d expected 17..32", lat);
      else passCount++;
    end
    checkCount++;
    if (data_out_2 !== 27'h0003000) $display("[TB] FAIL ch2_hold: got %h expected 0003000", data_out_2);
    else passCount++;
    checkCount++;
    if (obs1.size() != 0) $display("[TB] FAIL ch2_no_action_1: got %0d expected 0", obs1.size());
    else passCount++;
  endtask

  task automatic test_ch1_basic;
    time tAcc, ot, lat;
    logic [7:0] e, o;
    do_reset();
    exp1.push_back(8'hA5);
    send1(8'hA5, tAcc);
    repeat (20) @(negedge clk_125);
    checkCount++;
    if (obs1.size() != 1) $display("[TB] FAIL ch1_pulse_count: got %0d expected 1", obs1.size());
    else passCount++;
    checkCount++;
    if (obs1.size() == 0) $display("[TB] FAIL ch1_data: got no pulse expected %h", exp1[0]);
    else begin
      e = exp1.pop_front(); o = obs1.pop_front(); ot = obs1T.pop_front();
      if (o !== e) $display("[TB] FAIL ch1_data: got %h expected %h", o, e);
      else passCount++;
      lat = ot - 5 - tAcc;
      checkCount++;
      if (!(lat > 20 && lat <= 40)) $display("[TB] FAIL ch1_latency: got %0d expected 21..40", lat);
      else passCount++;
    end
    checkCount++;
    if (data_out_2 !== 27'h0) $display("[TB] FAIL ch1_data_out_2: got %h expected 0", data_out_2);
    else passCount++;
  endtask

  task automatic test_busy_drop;
    time tAcc;
    logic [7:0] e, o;
    clear_queues();
    exp1.push_back(8'h11);
    @(negedge clk_125);
    trigger_1 = 1'b1; data_in_1 = 8'h11;
    @(negedge clk_125);
    data_in_1 = 8'h22;
    @(negedge clk_125);
    trigger_1 = 1'b0; data_in_1 = '0;
    repeat (25) @(negedge clk_125);
    checkCount++;
    if (obs1.size() != 1) $display("[TB] FAIL busy_pulse_count: got %0d expected 1", obs1.size());
    else passCount++;
    checkCount++;
    if (obs1.size() == 0) $display("[TB] FAIL busy_data: got no pulse expected 11");
    else begin
      e = exp1.pop_front(); o = obs1.pop_front(); void'(obs1T.pop_front());
      if (o !== e) $display("[TB] FAIL busy_data: got %h expected %h", o, e);
      else passCount++;
    end
    checkCount++;
    if (data_out_1 !== 8'h11) $display("[TB] FAIL busy_data_out_1: got %h expected 11", data_out_1);
    else passCount++;
    clear_queues();
    exp1.push_back(8'h44);
    send1(8'h44, tAcc);
    repeat (25) @(negedge clk_125);
    checkCount++;
    if (obs1.size() != 1) $display("[TB] FAIL idle_again: got %0d pulses expected 1", obs1.size());
    else begin
      e = exp1.pop_front(); o = obs1.pop_front();
      if (o !== e) $display("[TB] FAIL idle_again: got %h expected %h", o, e);
      else passCount++;
    end
  endtask

  task automatic test_simultaneous;
    time t1, t2;
    clear_queues();
    exp1.push_back(8'h33);
    exp2.push_back(27'h7FFFFFF);
    fork
      send1(8'h33, t1);
      send2(27'h7FFFFFF, t2);
    join
    repeat (25) @(negedge clk_125);
    checkCount++;
    if (obs1.size() != 1) $display("[TB] FAIL sim_ch1: got %0d pulses expected 1", obs1.size());
    else if (obs1[0] !== exp1[0]) $display("[TB] FAIL sim_ch1: got %h expected %h", obs1[0], exp1[0]);
    else passCount++;
    checkCount++;
    if (obs2.size() != 1) $display("[TB] FAIL sim_ch2: got %0d pulses expected 1", obs2.size());
    else if (obs2[0] !== exp2[0]) $display("[TB] FAIL sim_ch2: got %h expected %h", obs2[0], exp2[0]);
    else passCount++;
    clear_queues();
  endtask

  task automatic test_reset_midflight;
    do_reset();
    @(negedge clk_100);
    trigger_2 = 1'b1; data_in_2 = 27'h1234567;
    @(posedge clk_100);
    #2 reset = 1'b1;
    @(negedge clk_100);
    trigger_2 = 1'b0; data_in_2 = '0;
    repeat (12) @(negedge clk_125);
    reset = 1'b0;
    repeat (40) @(negedge clk_125);
    checkCount++;
    if (obs2.size() != 0) $display("[TB] FAIL midflight_no_action: got %0d pulses expected 0", obs2.size());
    else passCount++;
    checkCount++;
    if (data_out_2 !== 27'h0) $display("[TB] FAIL midflight_data_out_2: got %h expected 0", data_out_2);
    else passCount++;
    clear_queues();
  endtask

  task automatic test_reset_window;
    time tAcc;
    clear_queues();
    @(negedge clk_125);
    reset = 1'b1;
    repeat (12) @(negedge clk_125);
    reset = 1'b0;
    @(posedge clk_125);
    send2(27'h5555555, tAcc);
    repeat (30) @(negedge clk_125);
    checkCount++;
    if (obs2.size() != 0) $display("[TB] FAIL reset_window_ignored: got %0d pulses expected 0", obs2.size());
    else passCount++;
    clear_queues();
  endtask

  task automatic test_back_to_back;
    time tAcc;
    logic [7:0] e, o;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      exp1.push_back(8'(i));
      send1(8'(i), tAcc);
      repeat (10) @(negedge clk_125);
    end
    repeat (10) @(negedge clk_125);
    checkCount++;
    if (obs1.size() != 8) $display("[TB] FAIL b2b_count: got %0d expected 8", obs1.size());
    else passCount++;
    for (int i = 0; i < 8; i++) begin
      checkCount++;
      e = exp1.pop_front();
      if (obs1.size() == 0) $display("[TB] FAIL b2b_data_%0d: got no pulse expected %h", i, e);
      else begin
        o = obs1.pop_front();
        if (o !== e) $display("[TB] FAIL b2b_data_%0d: got %h expected %h", i, o, e);
        else passCount++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_ch2_basic();
    test_ch1_basic();
    test_busy_drop();
    test_simultaneous();
    test_reset_midflight();
    test_reset_window();
    test_back_to_back();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
